aes_ctr_block_gen: RTL and testbench

- Parametrised AXI-Stream source of AES-CTR counter blocks, the next-generation replacement for the single-lane counter path inside aes256_ctr_mode.
- Emits LANES counter blocks per beat so that several AES-256 cores can be fed in parallel.
- Increments only the low CTR_W bits of the IV, as in NIST SP800-38A, and reports wrap-around of that field.
- Sits between the config/IV registers and the AES core array; its outputs are XORed with s_axis data downstream.

---
 rtl/aes_ctr_block_gen.sv | 121 ++++++++++++
 tb/tb_aes_ctr_block_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_block_gen.sv
// AES-CTR counter block source: emits LANES counter blocks per AXI-Stream beat,
// incrementing only the low CTR_W bits and flagging wrap-around of that field.

module aes_ctr_lane #(
  parameter int CTR_W = 32,
  parameter int IDX   = 0
) (
  input  logic [127:0] base,
  output logic [127:0] blk,
  output logic         carry
);
  localparam logic [127:0] MASK = (CTR_W >= 128) ? {128{1'b1}} : ((128'd1 << CTR_W) - 128'd1);

  logic [128:0] sum;

  always_comb begin
    sum   = {1'b0, base & MASK} + 129'(IDX);
    blk   = (base & ~MASK) | (sum[127:0] & MASK);
    carry = sum > {1'b0, MASK};
  end
endmodule

module aes_ctr_block_gen #(
  parameter int LANES = 1,
  parameter int CTR_W = 32,
  parameter int NUM_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [127:0]         iv,
  input  logic [NUM_W-1:0]     num_blocks,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tvalid,
  output logic [128*LANES-1:0] m_axis_tdata,
  output logic [LANES-1:0]     m_axis_tlane,
  output logic                 m_axis_tlast,
  output logic                 busy,
  output logic                 done,
  output logic                 wrapped
);
  typedef enum logic {IDLE, RUN} state_t;

  // Wide enough to compare rem against lane indices without truncation.
  localparam int CW = (NUM_W > 4) ? NUM_W + 1 : 5;

  state_t                  state, state_nxt;
  logic [127:0]            ctr;
  logic [NUM_W-1:0]        rem;
  logic                    wrap_q;
  logic [LANES:0][127:0]   blk;
  logic [LANES:0]          cy;
  logic [LANES-1:0]        lane_vld;
  logic                    hs, last, accept, beat_wrap;

  // Lane LANES is the next beat's base, and its carry is the advance carry.
  genvar i;
  generate
    for (i = 0; i <= LANES; i++) begin : g_lane
      aes_ctr_lane #(.CTR_W(CTR_W), .IDX(i)) u_lane (
        .base  (ctr),
        .blk   (blk[i]),
        .carry (cy[i])
      );
    end
    for (i = 0; i < LANES; i++) begin : g_out
      assign lane_vld[i] = CW'(rem) > CW'(i);
      assign m_axis_tdata[128*i +: 128] = m_axis_tvalid ? blk[i] : 128'd0;
    end
  endgenerate

  assign last      = CW'(rem) <= CW'(LANES);
  assign hs        = m_axis_tvalid & m_axis_tready;
  assign accept    = (state == IDLE) & start;
  assign beat_wrap = |(cy[LANES-1:0] & lane_vld);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && num_blocks != '0) state_nxt = RUN;
      RUN:  if (hs && last)                state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_axis_tvalid = (state == RUN);
    busy          = (state == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr    <= '0;
      rem    <= '0;
      wrap_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= (accept && num_blocks == '0) || (hs && last);
      if (accept) begin
        ctr    <= iv;
        rem    <= num_blocks;
        wrap_q <= 1'b0;
      end else if (hs) begin
        wrap_q <= wrap_q | beat_wrap | (~last & cy[LANES]);
        if (!last) begin
          ctr <= blk[LANES];
          rem <= rem - NUM_W'(LANES);
        end
      end
    end
  end

  assign m_axis_tlane = m_axis_tvalid ? lane_vld : '0;
  assign m_axis_tlast = m_axis_tvalid & last;
  assign wrapped      = wrap_q | (m_axis_tvalid & beat_wrap);
endmodule

// File: tb/tb_aes_ctr_block_gen.sv
// Directed bench for aes_ctr_block_gen: three instances (LANES=1,2,4) on one clock.

module tb_aes_ctr_block_gen;
  logic clk = 1'b0, rst = 1'b1;
  logic [127:0] iv = '0;
  logic [31:0]  num_blocks = '0;
  logic tready = 1'b1;
  logic start1 = 1'b0, start2 = 1'b0, start4 = 1'b0;

  logic tv1, tl1, bz1, dn1, wr1; logic [127:0] d1; logic [0:0] ln1;
  logic tv2, tl2, bz2, dn2, wr2; logic [255:0] d2; logic [1:0] ln2;
  logic tv4, tl4, bz4, dn4, wr4; logic [511:0] d4; logic [3:0] ln4;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  aes_ctr_block_gen #(.LANES(1), .CTR_W(32), .NUM_W(32)) u1 (
    .clk(clk), .rst(rst), .start(start1), .iv(iv), .num_blocks(num_blocks),
    .m_axis_tready(tready), .m_axis_tvalid(tv1), .m_axis_tdata(d1), .m_axis_tlane(ln1),
    .m_axis_tlast(tl1), .busy(bz1), .done(dn1), .wrapped(wr1));
  aes_ctr_block_gen #(.LANES(2), .CTR_W(32), .NUM_W(32)) u2 (
    .clk(clk), .rst(rst), .start(start2), .iv(iv), .num_blocks(num_blocks),
    .m_axis_tready(tready), .m_axis_tvalid(tv2), .m_axis_tdata(d2), .m_axis_tlane(ln2),
    .m_axis_tlast(tl2), .busy(bz2), .done(dn2), .wrapped(wr2));
  aes_ctr_block_gen #(.LANES(4), .CTR_W(32), .NUM_W(32)) u4 (
    .clk(clk), .rst(rst), .start(start4), .iv(iv), .num_blocks(num_blocks),
    .m_axis_tready(tready), .m_axis_tvalid(tv4), .m_axis_tdata(d4), .m_axis_tlane(ln4),
    .m_axis_tlast(tl4), .busy(bz4), .done(dn4), .wrapped(wr4));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] IV_A = 128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF;
  localparam logic [127:0] IV_B = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_FFFFFFFF;
  localparam logic [127:0] IV_C = 128'h00000000_11111111_22222222_33333330;
  localparam logic [127:0] IV_D = 128'h0badf00d_12345678_9abcdef0_00000010;

  initial begin
    logic [127:0] held;
    logic held_last;
    bit stalled;
    int nhs;

    // reset state
    #2;
    chk("rst_tvalid", tv1, 0); chk("rst_tdata1", d1, 0); chk("rst_tdata4", d4[127:0], 0);
    chk("rst_tlane4", ln4, 0); chk("rst_tlast", tl1, 0); chk("rst_busy", bz1, 0);
    chk("rst_done", dn1, 0); chk("rst_wrapped", wr2, 0);
    tick(); rst = 1'b0; tick();

    // LANES=1 sustained run of 4
    iv = IV_A; num_blocks = 4; tready = 1'b1; start1 = 1'b1;
    tick(); start1 = 1'b0; iv = '0; num_blocks = 99;
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("t1_valid%0d", b), tv1, 1);
      chk($sformatf("t1_data%0d", b), d1, {IV_A[127:32], 32'hFCFDFEFF + 32'(b)});
      chk($sformatf("t1_last%0d", b), tl1, (b == 3));
      chk($sformatf("t1_done%0d", b), dn1, 0);
      tick();
    end
    chk("t1_end_valid", tv1, 0); chk("t1_done", dn1, 1); chk("t1_busy", bz1, 0);
    chk("t1_wrapped", wr1, 0);
    tick(); chk("t1_done_pulse", dn1, 0);

    // LANES=2 wrap inside one beat
    iv = IV_B; num_blocks = 2; start2 = 1'b1;
    tick(); start2 = 1'b0;
    chk("t2_lane0", d2[127:0], IV_B);
    chk("t2_lane1", d2[255:128], {IV_B[127:32], 32'h0});
    chk("t2_tlane", ln2, 2'b11); chk("t2_last", tl2, 1); chk("t2_wrapped", wr2, 1);
    tick();
    chk("t2_done", dn2, 1); chk("t2_valid_off", tv2, 0); chk("t2_wrap_hold", wr2, 1);
    tick(); tick(); chk("t2_wrap_sticky", wr2, 1);
    iv = {IV_B[127:32], 32'h0}; num_blocks = 1; start2 = 1'b1;
    tick(); start2 = 1'b0;
    chk("t2_wrap_clear", wr2, 0); chk("t2_tlane_one", ln2, 2'b01);
    tick(); chk("t2b_done", dn2, 1);
    tick();

    // LANES=4, 6 blocks, stall with ignored start mid-run
    iv = IV_C; num_blocks = 6; start4 = 1'b1;
    tick(); start4 = 1'b0;
    chk("t3_tlane0", ln4, 4'b1111); chk("t3_last0", tl4, 0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("t3_b0_lane%0d", k), d4[128*k +: 128], IV_C + 128'(k));
    tready = 1'b0; iv = IV_A; num_blocks = 1; start4 = 1'b1;
    tick(); start4 = 1'b0;
    tick();
    chk("t3_stall_valid", tv4, 1); chk("t3_stall_lane0", d4[127:0], IV_C);
    chk("t3_stall_tlane", ln4, 4'b1111); chk("t3_stall_last", tl4, 0);
    tready = 1'b1;
    tick();
    chk("t3_tlane1", ln4, 4'b0011); chk("t3_last1", tl4, 1);
    chk("t3_b1_lane0", d4[127:0], IV_C + 128'd4);
    chk("t3_b1_lane1", d4[255:128], IV_C + 128'd5);
    chk("t3_b1_lane2", d4[383:256], IV_C + 128'd6);
    tick();
    chk("t3_done", dn4, 1); chk("t3_valid_off", tv4, 0);
    tick();

    // LANES=1 random backpressure, 20 blocks
    iv = IV_D; num_blocks = 20; start1 = 1'b1;
    tick(); start1 = 1'b0;
    stalled = 0; nhs = 0; held = '0; held_last = 0;
    for (int c = 0; c < 400 && nhs < 20; c++) begin
      chk("bp_valid", tv1, 1);
      if (stalled) begin
        chk("bp_hold_data", d1, held); chk("bp_hold_last", tl1, held_last);
      end
      tready = ($urandom_range(0, 3) != 0);
      if (tv1 && tready) begin
        chk("bp_data", d1, IV_D + 128'(nhs)); chk("bp_last", tl1, (nhs == 19));
        nhs++; stalled = 0;
      end else begin
        stalled = 1; held = d1; held_last = tl1;
      end
      tick();
    end
    chk("bp_count", 128'(nhs), 128'd20);
    chk("bp_done", dn1, 1); chk("bp_valid_off", tv1, 0);
    tready = 1'b1;
    tick();

    // zero-length run
    num_blocks = 0; start1 = 1'b1;
    tick(); start1 = 1'b0;
    chk("z_valid", tv1, 0); chk("z_done", dn1, 1); chk("z_busy", bz1, 0);
    tick(); chk("z_done_pulse", dn1, 0);

    // wrap, stall, then async reset mid-run
    iv = {IV_A[127:32], 32'hFFFFFFFF}; num_blocks = 5; start1 = 1'b1;
    tick(); start1 = 1'b0;
    chk("r_wrap_pre", wr1, 0);
    tick();
    chk("r_data_wrapped", d1, {IV_A[127:32], 32'h0}); chk("r_wrapped", wr1, 1);
    tready = 1'b0;
    tick(); tick();
    #2 rst = 1'b1; #1;
    chk("r_valid", tv1, 0); chk("r_tdata", d1, 0); chk("r_tlane", ln1, 0);
    chk("r_busy", bz1, 0); chk("r_wrap", wr1, 0); chk("r_done", dn1, 0);
    tick(); rst = 1'b0; tready = 1'b1;
    tick(); chk("r_no_done", dn1, 0);
    iv = IV_D + 128'd5; num_blocks = 1; start1 = 1'b1;
    tick(); start1 = 1'b0;
    chk("r2_data", d1, IV_D + 128'd5); chk("r2_last", tl1, 1); chk("r2_wrap", wr1, 0);
    tick(); chk("r2_done", dn1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
